// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - pipeline control inputs and per-stage enable/flush outputs
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_freeze;
  logic             branch_taken;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout_err;

  modport master (
    output hazard_freeze, branch_taken, mem_r_en, mem_w_en, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, stall_cnt, timeout_err
  );

  modport slave (
    input  hazard_freeze, branch_taken, mem_r_en, mem_w_en, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, stall_cnt, timeout_err
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - 5-stage pipeline sequencer: stall/flush control, memory timeout, stall counter
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              err_q, err_nxt;
  logic              mem_access, arbitrate;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic              if_id_flush, id_ex_flush;

  assign mem_access = bus.mem_r_en | bus.mem_w_en;

  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    err_nxt     = err_q;
    arbitrate   = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_access && !bus.mem_ready) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else begin
            arbitrate = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Keep waiting on mem_ready even if the access request drops.
          if (!bus.mem_ready) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
              state_nxt = ERR;
              err_nxt   = 1'b1;
            end
          end else begin
            arbitrate = 1'b1;
            state_nxt = RUN;
            wait_nxt  = '0;
          end
        end
        ERR: ;
        default: state_nxt = RUN;
      endcase

      // A taken branch squashes the frozen wrong-path instruction, so it outranks the freeze.
      if (arbitrate) begin
        if (bus.branch_taken) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.hazard_freeze) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
          id_ex_flush = 1'b1;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
      if (!pc_en && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  localparam logic [6:0] V_IDLE   = 7'b1111100;
  localparam logic [6:0] V_STALL  = 7'b0000000;
  localparam logic [6:0] V_FREEZE = 7'b0011101;
  localparam logic [6:0] V_BRANCH = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipe_stall_ctrl_if #(.CNT_W(4)) bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] vec;
  assign vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush};

  task automatic drive(input logic hz, input logic br, input logic rd, input logic wr, input logic rdy);
    bus.hazard_freeze = hz;
    bus.branch_taken  = br;
    bus.mem_r_en      = rd;
    bus.mem_w_en      = wr;
    bus.mem_ready     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (vec !== V_STALL) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, vec, V_STALL);
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec !== V_IDLE) begin
      bad++;
      $display("FAIL idle_outputs got=%b exp=%b", vec, V_IDLE);
    end
    total++;
    if (bus.stall_cnt !== 4'd0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_regs got cnt=%0d err=%b exp cnt=0 err=0", bus.stall_cnt, bus.timeout_err);
    end
    next_cycle();
  endtask

  task automatic test_freeze();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (vec !== V_FREEZE) begin
        bad++;
        $display("FAIL freeze cyc=%0d got=%b exp=%b", i, vec, V_FREEZE);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (vec !== V_IDLE || bus.stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL freeze_after got=%b cnt=%0d exp=%b cnt=2", vec, bus.stall_cnt, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_branch_freeze();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    total++;
    if (vec !== V_BRANCH) begin
      bad++;
      $display("FAIL branch_freeze got=%b exp=%b", vec, V_BRANCH);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL branch_cnt got=%0d exp=2", bus.stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (vec !== V_STALL) begin
        bad++;
        $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, vec, V_STALL);
      end
      next_cycle();
    end
    drive(0, 0, 1, 0, 1);
    @(negedge clk);
    total++;
    if (vec !== V_IDLE) begin
      bad++;
      $display("FAIL mem_ready_cycle got=%b exp=%b", vec, V_IDLE);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (vec !== V_IDLE || bus.stall_cnt !== 4'd6) begin
      bad++;
      $display("FAIL mem_back_to_run got=%b cnt=%0d exp=%b cnt=6", vec, bus.stall_cnt, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // Single-cycle store: zero stall.
    drive(0, 0, 0, 1, 1);
    @(negedge clk);
    total++;
    if (vec !== V_IDLE) begin
      bad++;
      $display("FAIL single_cycle_mem got=%b exp=%b", vec, V_IDLE);
    end
    next_cycle();
    // One wait cycle, then ready with a branch resolved in the same cycle.
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if (vec !== V_STALL) begin
      bad++;
      $display("FAIL wait_ignores_hazard got=%b exp=%b", vec, V_STALL);
    end
    next_cycle();
    drive(1, 1, 1, 0, 1);
    @(negedge clk);
    total++;
    if (vec !== V_BRANCH) begin
      bad++;
      $display("FAIL ready_branch got=%b exp=%b", vec, V_BRANCH);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_cnt !== 4'd7) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d exp=7", bus.stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (vec !== V_STALL || bus.timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait cyc=%0d got=%b err=%b exp=%b err=0", i, vec, bus.timeout_err, V_STALL);
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if (vec !== V_STALL || bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_err got=%b err=%b exp=%b err=1", vec, bus.timeout_err, V_STALL);
    end
    next_cycle();
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    total++;
    if (vec !== V_STALL || bus.timeout_err !== 1'b1 || bus.stall_cnt !== 4'd15) begin
      bad++;
      $display("FAIL err_sticky got=%b err=%b cnt=%0d exp=%b err=1 cnt=15", vec, bus.timeout_err, bus.stall_cnt, V_STALL);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (vec !== V_STALL) begin
      bad++;
      $display("FAIL err_reset_outputs got=%b exp=%b", vec, V_STALL);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec !== V_IDLE || bus.timeout_err !== 1'b0 || bus.stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL err_cleared got=%b err=%b cnt=%0d exp=%b err=0 cnt=0", vec, bus.timeout_err, bus.stall_cnt, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    drive(0, 0, 1, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (vec !== V_IDLE || bus.stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_wait got=%b cnt=%0d exp=%b cnt=0", vec, bus.stall_cnt, V_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (bus.stall_cnt !== 4'((i > 15) ? 15 : i)) begin
        bad++;
        $display("FAIL saturate cyc=%0d got=%0d exp=%0d", i, bus.stall_cnt, (i > 15) ? 15 : i);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (bus.stall_cnt !== 4'd15 || vec !== V_IDLE) begin
      bad++;
      $display("FAIL saturate_hold got cnt=%0d vec=%b exp cnt=15 vec=%b", bus.stall_cnt, vec, V_IDLE);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_branch_freeze();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencer for the 5-stage ARM core. Merges the hazard-unit freeze, EXE-stage branch-taken and the data-memory ready handshake into per-stage register enables and flushes. Holds the whole pipeline through multi-cycle memory accesses and enforces a memory timeout. Keeps a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 64, max cycles spent in MEM_WAIT before declaring an error (≥2)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
hazard_freeze  in  1  RAW freeze from hazard unit (ID stage)
branch_taken  in  1  branch resolved taken in EXE
mem_r_en  in  1  MEM stage load in progress
mem_w_en  in  1  MEM stage store in progress
mem_ready  in  1  data memory has completed current access
pc_en  out  1  PC register enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EXE/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  clear IF/ID on next edge
id_ex_flush  out  1  clear ID/EX on next edge (inject bubble)
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0
timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. State, wait counter (ceil(log2(MEM_TIMEOUT))+1 bits), stall_cnt and timeout_err are registered. Enables and flushes are combinational (Mealy) from state and inputs.
- Reset: on the clk edge with rst=1: state←RUN, wait_cnt←0, stall_cnt←0, timeout_err←0. While rst=1, all enables=0 and both flushes=0, regardless of state.
- mem_access = mem_r_en | mem_w_en.
- RUN, mem_access & !mem_ready:
  - All five enables 0, flushes 0.
  - Next state MEM_WAIT, wait_cnt←1.
  - Hazard and branch are ignored this cycle. They are re-evaluated when the access completes.
- RUN, otherwise, evaluated in priority order:
  - branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1. PC loads the target; the wrong-path IF/ID and ID/EX contents are squashed. Any hazard_freeze in the same cycle is ignored, because the frozen instruction is wrong-path.
  - else hazard_freeze: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1 (bubble into EXE), ex_mem_en=1, mem_wb_en=1, if_id_flush=0.
  - else: all enables 1, flushes 0.
- MEM_WAIT, mem_ready=0:
  - All enables 0, flushes 0; wait_cnt increments.
  - If wait_cnt = MEM_TIMEOUT-1: next state ERR, timeout_err←1.
- MEM_WAIT, mem_ready=1:
  - Outputs follow the RUN rules, excluding the memory-stall check; branch/hazard arbitration is as in RUN.
  - Next state RUN, wait_cnt←0.
- ERR: all enables 0, flushes 0. State and timeout_err hold until rst.
- Deassertion of mem_access while in MEM_WAIT is illegal. The block still waits for mem_ready.
- stall_cnt: increments on every non-reset edge where pc_en=0, including ERR cycles. It saturates at 2^CNT_W-1 with no wrap.
- Single-cycle memory (mem_ready=1 with access) causes zero stall cycles.
- Latency: a memory access needing N ready-low cycles stalls the pipeline exactly N cycles.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then rst=0 with all inputs 0 → during rst enables=0; after, all enables=1, flushes=0, stall_cnt=0, timeout_err=0.
2. RAW freeze: hazard_freeze=1 for 2 cycles → pc_en=if_id_en=0, id_ex_flush=1, id_ex_en=ex_mem_en=mem_wb_en=1 for 2 cycles; stall_cnt=2.
3. Branch + freeze same cycle: branch_taken=1, hazard_freeze=1 → all enables 1, both flushes 1; stall_cnt unchanged.
4. Memory wait: mem_r_en=1, mem_ready low for 4 cycles then high → enables 0 for exactly 4 cycles; the ready cycle has all enables 1; state back to RUN; stall_cnt +=4.
5. Timeout (MEM_TIMEOUT=8): mem_w_en=1, mem_ready held 0 → after 8 stalled cycles state=ERR, timeout_err=1, enables stay 0; a later mem_ready=1 has no effect; rst clears everything.
6. Reset mid-wait and saturation (CNT_W=4): assert rst during MEM_WAIT → next cycle RUN, stall_cnt=0. Then force 20 stall cycles → stall_cnt holds at 15.
